floppy_bank: RTL and testbench
==============================

Name: floppy_bank

Overview:
- Multi-channel floppy-drive tone generator; successor to the single-drive step/dir generator.
- Fully synchronous: no gated clocks, no derived-edge flops.
- Each channel toggles STEP at a programmable half-period, tracks head position and bounces DIR at the track limits.
- After reset, each channel homes its head to track 0 before it accepts play commands. Sits between the MIDI note decoder and the drive connectors.

Parameters:
- CHANNELS, 4, number of independent drives.
- CTR_W, 22, width of the half-period counter and of each setpoint.
- TRACKS, 80, number of head positions (0..TRACKS-1); must be >= 2.
- HOME_DIV, 200000, half-period in clk cycles used during homing; must be >= 1 and < 2^CTR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  CHANNELS  per-channel play enable; bit i controls channel i.
- setpoint  in  CHANNELS*CTR_W  half-period per channel in clk cycles; channel i occupies bits [i*CTR_W +: CTR_W].
- step  out  CHANNELS  drive STEP lines; a falling edge (1->0) is one head step.
- dir  out  CHANNELS  drive DIR lines; 1 = toward track 0, 0 = inward.
- sel_n  out  CHANNELS  active-low drive select.
- homed  out  CHANNELS  1 once the channel has finished homing.

Behaviour:
- Reset (rst=1 at a clk edge), every channel:
  - state=HOME, counter=0, pos=TRACKS-1, home_cnt=0.
  - step=1, dir=1, homed=0.
- Register and counter widths:
  - Half-period counter: CTR_W bits.
  - pos and home_cnt: clog2(TRACKS) bits.
- All outputs are registered except sel_n; sel_n[i] = ~(enable[i] | (state==HOME)), combinational from the state register and enable.
- Per-channel FSM states are HOME, IDLE and PLAY.
- HOME state:
  - Ignores enable and setpoint. dir held 1.
  - Counter increments each clk. When counter+1 >= HOME_DIV: counter<=0 and step<=~step.
  - Each 1->0 step transition increments home_cnt.
  - The clk on which that transition makes home_cnt reach TRACKS: state<=IDLE, pos<=0, dir<=0, homed<=1, counter<=0, step stays 0.
  - Then step returns high on the first PLAY toggle.
- IDLE state:
  - step and dir hold, counter=0.
  - Goes to PLAY on the first clk with enable[i]=1.
- PLAY state:
  - enable[i]=0: next clk state<=IDLE, counter<=0, step and dir hold their value. No pulse is truncated into a partial step beyond the held level.
  - setpoint==0: silent; counter held 0, step holds, state stays PLAY.
  - setpoint>=1: counter increments. When counter+1 >= setpoint: counter<=0 and step<=~step.
  - STEP period is 2*setpoint clks; setpoint=1 toggles every clk.
- Setpoint changes take effect on the next clk compare. No latching is applied. If counter+1 >= the new value, step toggles and counter clears on that clk.
- Position tracking in PLAY, on each 1->0 step transition:
  - dir=0: pos<=pos+1. If pos+1 == TRACKS-1, dir<=1 on the same clk.
  - dir=1: pos<=pos-1. If pos-1 == 0, dir<=0 on the same clk.
  - pos never leaves 0..TRACKS-1. The dir change is visible in the same cycle as the step falling edge it follows; the next pulse uses the new direction.
- Channels are fully independent; no shared state except clk/rst.
- rst mid-operation in any state returns all channels to HOME on that clk. It overrides any simultaneous toggle or enable.
- enable asserted during HOME: no effect except sel_n (already low). After homing completes, the channel enters IDLE, then PLAY one clk later if enable is still high.

Test Plan:
- Reset homing, HOME_DIV=4, TRACKS=80, CHANNELS=2, rst 1 clk -> step=1, dir=1, homed=0, sel_n=2'b00; 80 falling edges 8 clks apart; homed=1 and dir=0 right after the 80th falling edge, i.e. 8*80-4=636 clks after rst deasserts.
- Play rate, after homing, enable=1, setpoint=5 -> step toggles every 5 clks (period 10); sel_n[i]=0; the other channel with enable=0 stays idle with sel_n=1.
- Bounce at limits, setpoint=1, TRACKS=80 -> dir goes 0->1 on the 79th falling edge (pos=79), back to 0 after 79 more (pos=0); pos never exceeds 79.
- Live setpoint change: setpoint=100, counter at 50, write setpoint=20 -> toggle and counter clear on the next clk; thereafter toggles every 20 clks.
- Pause and silent: enable drops mid half-period -> next clk IDLE, step/dir frozen, sel_n=1; re-enable resumes from counter=0. setpoint=0 with enable=1 -> no toggles for 1000 clks.
- Reset mid-play: rst asserted while step is toggling -> next clk step=1, dir=1, homed=0, and homing restarts from home_cnt=0.

Source files
------------

// File: rtl/floppy_bank.sv
// Multi-channel floppy-drive tone generator: each channel homes its head to
// track 0, then toggles STEP at a programmable half-period and bounces DIR at the track limits.
module floppy_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CTR_W    = 22,
    parameter int unsigned TRACKS   = 80,
    parameter int unsigned HOME_DIV = 200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS*CTR_W-1:0] setpoint,
    output logic [CHANNELS-1:0]       step,
    output logic [CHANNELS-1:0]       dir,
    output logic [CHANNELS-1:0]       sel_n,
    output logic [CHANNELS-1:0]       homed
);

    localparam int unsigned POS_W = $clog2(TRACKS);
    localparam int unsigned CNT_W = CTR_W + 1;

    typedef enum logic [1:0] {
        ST_HOME = 2'd0,
        ST_IDLE = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_e             state_q, state_d;
        logic [CTR_W-1:0]   ctr_q, ctr_d;
        logic [POS_W-1:0]   pos_q, pos_d;
        logic [POS_W-1:0]   home_cnt_q, home_cnt_d;
        logic               step_q, step_d;
        logic               dir_q, dir_d;
        logic               homed_q, homed_d;
        logic [CTR_W-1:0]   sp;
        logic [CNT_W-1:0]   ctr_inc;

        assign sp      = setpoint[i*CTR_W +: CTR_W];
        // One extra bit so the compare against the half-period never wraps.
        assign ctr_inc = {1'b0, ctr_q} + CNT_W'(1);

        // Next-state: homing sweep, idle hold, and tone generation with head bounce.
        always_comb begin
            state_d    = state_q;
            ctr_d      = ctr_q;
            pos_d      = pos_q;
            home_cnt_d = home_cnt_q;
            step_d     = step_q;
            dir_d      = dir_q;
            homed_d    = homed_q;

            unique case (state_q)
                ST_HOME: begin
                    dir_d = 1'b1;
                    if (ctr_inc >= CNT_W'(HOME_DIV)) begin
                        ctr_d  = '0;
                        step_d = ~step_q;
                        if (step_q) begin
                            if (home_cnt_q == POS_W'(TRACKS - 1)) begin
                                state_d = ST_IDLE;
                                pos_d   = '0;
                                dir_d   = 1'b0;
                                homed_d = 1'b1;
                            end else begin
                                home_cnt_d = home_cnt_q + POS_W'(1);
                            end
                        end
                    end else begin
                        ctr_d = ctr_inc[CTR_W-1:0];
                    end
                end
                ST_IDLE: begin
                    ctr_d = '0;
                    if (enable[i]) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (!enable[i]) begin
                        state_d = ST_IDLE;
                        ctr_d   = '0;
                    end else if (sp == '0) begin
                        ctr_d = '0;
                    end else if (ctr_inc >= {1'b0, sp}) begin
                        ctr_d  = '0;
                        step_d = ~step_q;
                        // A falling STEP edge moves the head; reverse at either end stop.
                        if (step_q) begin
                            if (dir_q) begin
                                pos_d = pos_q - POS_W'(1);
                                if (pos_q == POS_W'(1)) begin
                                    dir_d = 1'b0;
                                end
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                                if (pos_q == POS_W'(TRACKS - 2)) begin
                                    dir_d = 1'b1;
                                end
                            end
                        end
                    end else begin
                        ctr_d = ctr_inc[CTR_W-1:0];
                    end
                end
                default: begin
                    state_d = ST_HOME;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_HOME;
                ctr_q      <= '0;
                pos_q      <= POS_W'(TRACKS - 1);
                home_cnt_q <= '0;
                step_q     <= 1'b1;
                dir_q      <= 1'b1;
                homed_q    <= 1'b0;
            end else begin
                state_q    <= state_d;
                ctr_q      <= ctr_d;
                pos_q      <= pos_d;
                home_cnt_q <= home_cnt_d;
                step_q     <= step_d;
                dir_q      <= dir_d;
                homed_q    <= homed_d;
            end
        end

        assign step[i]  = step_q;
        assign dir[i]   = dir_q;
        assign homed[i] = homed_q;
        // Drive stays selected throughout homing regardless of enable.
        assign sel_n[i] = ~(enable[i] | (state_q == ST_HOME));
    end

endmodule

// File: tb/tb_floppy_bank.sv
// Self-checking bench for floppy_bank: random and directed stimulus against a
// behavioural model of homing, tone rate and head bounce.
module tb_floppy_bank;

    localparam int NCH  = 2;
    localparam int CW   = 22;
    localparam int NTR  = 80;
    localparam int HDIV = 4;

    localparam int M_HOME = 0;
    localparam int M_IDLE = 1;
    localparam int M_PLAY = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    enable;
    logic [NCH*CW-1:0] setpoint;
    logic [NCH-1:0]    step;
    logic [NCH-1:0]    dir;
    logic [NCH-1:0]    sel_n;
    logic [NCH-1:0]    homed;

    int n_checks = 0;
    int n_errors = 0;

    floppy_bank #(
        .CHANNELS (NCH),
        .CTR_W    (CW),
        .TRACKS   (NTR),
        .HOME_DIV (HDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .setpoint (setpoint),
        .step     (step),
        .dir      (dir),
        .sel_n    (sel_n),
        .homed    (homed)
    );

    always #5 clk = ~clk;

    // Behavioural model: elapsed clocks in the current half-period, head as
    // integer position plus signed direction of travel.
    int m_mode    [NCH];
    int m_elapsed [NCH];
    int m_edges   [NCH];
    int m_pos     [NCH];
    int m_delta   [NCH];
    bit m_step    [NCH];
    bit m_homed   [NCH];

    function automatic int sp_of(int ch);
        return int'(setpoint[ch*CW +: CW]);
    endfunction

    function automatic void model_clk();
        for (int ch = 0; ch < NCH; ch++) begin
            if (rst) begin
                m_mode[ch] = M_HOME; m_elapsed[ch] = 0; m_edges[ch] = 0;
                m_pos[ch] = NTR - 1; m_delta[ch] = -1; m_step[ch] = 1'b1; m_homed[ch] = 1'b0;
            end else if (m_mode[ch] == M_HOME) begin
                m_elapsed[ch]++;
                if (m_elapsed[ch] >= HDIV) begin
                    m_elapsed[ch] = 0;
                    m_step[ch] = !m_step[ch];
                    if (!m_step[ch]) begin
                        m_edges[ch]++;
                        if (m_edges[ch] == NTR) begin
                            m_mode[ch] = M_IDLE; m_pos[ch] = 0; m_delta[ch] = 1; m_homed[ch] = 1'b1;
                        end
                    end
                end
            end else if (m_mode[ch] == M_IDLE) begin
                m_elapsed[ch] = 0;
                if (enable[ch]) m_mode[ch] = M_PLAY;
            end else begin
                if (!enable[ch]) begin
                    m_mode[ch] = M_IDLE; m_elapsed[ch] = 0;
                end else if (sp_of(ch) == 0) begin
                    m_elapsed[ch] = 0;
                end else begin
                    m_elapsed[ch]++;
                    if (m_elapsed[ch] >= sp_of(ch)) begin
                        m_elapsed[ch] = 0;
                        m_step[ch] = !m_step[ch];
                        if (!m_step[ch]) begin
                            m_pos[ch] += m_delta[ch];
                            if (m_pos[ch] == NTR - 1 || m_pos[ch] == 0) m_delta[ch] = -m_delta[ch];
                        end
                    end
                end
            end
        end
    endfunction

    // Expected {step, dir, homed, sel_n} from the model and current enable.
    function automatic logic [4*NCH-1:0] exp_all();
        logic [NCH-1:0] s, d, h, n;
        for (int ch = 0; ch < NCH; ch++) begin
            s[ch] = m_step[ch];
            d[ch] = (m_delta[ch] < 0);
            h[ch] = m_homed[ch];
            n[ch] = !(enable[ch] || m_mode[ch] == M_HOME);
        end
        return {s, d, h, n};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic set_sp(int ch, int v);
        setpoint[ch*CW +: CW] = CW'(v);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = '0; setpoint = '0;
        tick(); tick();
        n_checks++; if (step !== 2'b11)  begin n_errors++; $display("FAIL reset_step got=%b exp=11", step); end
        n_checks++; if (dir !== 2'b11)   begin n_errors++; $display("FAIL reset_dir got=%b exp=11", dir); end
        n_checks++; if (homed !== 2'b00) begin n_errors++; $display("FAIL reset_homed got=%b exp=00", homed); end
        n_checks++; if (sel_n !== 2'b00) begin n_errors++; $display("FAIL reset_sel_n got=%b exp=00", sel_n); end
    endtask

    task automatic test_homing();
        int falls = 0;
        logic [NCH-1:0] prev;
        logic [4*NCH-1:0] got, exp;
        rst = 1'b0;
        for (int t = 1; t <= 640; t++) begin
            prev = step;
            tick();
            if (prev[0] && !step[0]) falls++;
            got = {step, dir, homed, sel_n}; exp = exp_all();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL homing_model t=%0d got=%b exp=%b", t, got, exp); end
            if (t == 635) begin
                n_checks++; if (homed !== 2'b00) begin n_errors++; $display("FAIL homing_early homed=%b exp=00", homed); end
            end
            if (t == 636) begin
                n_checks++;
                if ({homed, dir, step} !== 6'b11_00_00 || falls != 80) begin
                    n_errors++; $display("FAIL homing_done homed=%b dir=%b step=%b falls=%0d exp 11/00/00/80", homed, dir, step, falls);
                end
            end
        end
        n_checks++; if (sel_n !== 2'b11) begin n_errors++; $display("FAIL homing_idle_sel_n got=%b exp=11", sel_n); end
    endtask

    task automatic test_bounce();
        int falls = 0;
        logic [NCH-1:0] prev;
        logic [4*NCH-1:0] got, exp;
        enable = 2'b01; set_sp(0, 1);
        for (int t = 1; t <= 330; t++) begin
            prev = step;
            tick();
            got = {step, dir, homed, sel_n}; exp = exp_all();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL bounce_model t=%0d got=%b exp=%b", t, got, exp); end
            if (prev[0] && !step[0]) begin
                falls++;
                if (falls == 78 || falls == 79 || falls == 157 || falls == 158) begin
                    n_checks++;
                    if (dir[0] !== ((falls == 79 || falls == 157) ? 1'b1 : 1'b0)) begin
                        n_errors++; $display("FAIL bounce_dir edge=%0d dir=%b", falls, dir[0]);
                    end
                end
            end
        end
        n_checks++; if (falls != 164) begin n_errors++; $display("FAIL bounce_rate falls=%0d exp=164", falls); end
        enable = 2'b00;
        tick();
    endtask

    task automatic test_play_rate();
        int last = 0, ntog = 0;
        logic [NCH-1:0] prev;
        logic [4*NCH-1:0] got, exp;
        enable = 2'b10; set_sp(1, 5);
        for (int t = 1; t <= 60; t++) begin
            prev = step;
            tick();
            got = {step, dir, homed, sel_n}; exp = exp_all();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rate_model t=%0d got=%b exp=%b", t, got, exp); end
            n_checks++; if (sel_n !== 2'b01) begin n_errors++; $display("FAIL rate_sel_n got=%b exp=01", sel_n); end
            if (prev[1] != step[1]) begin
                n_checks++;
                if ((ntog == 0 && t != 6) || (ntog > 0 && t - last != 5)) begin
                    n_errors++; $display("FAIL rate_interval toggle=%0d t=%0d last=%0d", ntog, t, last);
                end
                last = t; ntog++;
            end
        end
        n_checks++; if (ntog != 11) begin n_errors++; $display("FAIL rate_count got=%0d exp=11", ntog); end
    endtask

    task automatic test_live_setpoint();
        bit found = 0;
        int early = 0, gap = -1;
        logic [NCH-1:0] prev;
        logic [4*NCH-1:0] got, exp;
        for (int t = 0; t < 20 && !found; t++) begin
            prev = step; tick();
            if (prev[1] != step[1]) found = 1;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL live_sync no toggle within 20 clks"); end
        set_sp(1, 100);
        for (int t = 0; t < 50; t++) begin
            prev = step; tick();
            if (prev[1] != step[1]) early++;
        end
        n_checks++; if (early != 0) begin n_errors++; $display("FAIL live_hold toggles=%0d exp=0", early); end
        set_sp(1, 20);
        prev = step; tick();
        got = {step, dir, homed, sel_n}; exp = exp_all();
        n_checks++; if (got !== exp) begin n_errors++; $display("FAIL live_model got=%b exp=%b", got, exp); end
        n_checks++; if (step[1] === prev[1]) begin n_errors++; $display("FAIL live_immediate step=%b prev=%b", step[1], prev[1]); end
        for (int t = 1; t <= 25 && gap < 0; t++) begin
            prev = step; tick();
            if (prev[1] != step[1]) gap = t;
        end
        n_checks++; if (gap != 20) begin n_errors++; $display("FAIL live_period got=%0d exp=20", gap); end
    endtask

    task automatic test_pause_silent();
        logic s, d;
        int gap = -1, tog = 0;
        logic [NCH-1:0] prev;
        logic [4*NCH-1:0] got, exp;
        for (int t = 0; t < 7; t++) tick();
        enable[1] = 1'b0;
        tick();
        s = step[1]; d = dir[1];
        for (int t = 0; t < 20; t++) begin
            tick();
            got = {step, dir, homed, sel_n}; exp = exp_all();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL pause_model t=%0d got=%b exp=%b", t, got, exp); end
            n_checks++;
            if (step[1] !== s || dir[1] !== d || sel_n[1] !== 1'b1) begin
                n_errors++; $display("FAIL pause_frozen step=%b dir=%b sel_n=%b exp %b/%b/1", step[1], dir[1], sel_n[1], s, d);
            end
        end
        enable[1] = 1'b1;
        for (int t = 1; t <= 40 && gap < 0; t++) begin
            prev = step; tick();
            if (prev[1] != step[1]) gap = t;
        end
        n_checks++; if (gap != 21) begin n_errors++; $display("FAIL pause_resume got=%0d exp=21", gap); end
        set_sp(1, 0);
        for (int t = 0; t < 1000; t++) begin
            prev = step; tick();
            if (prev[1] != step[1]) tog++;
        end
        n_checks++; if (tog != 0) begin n_errors++; $display("FAIL silent toggles=%0d exp=0", tog); end
        got = {step, dir, homed, sel_n}; exp = exp_all();
        n_checks++; if (got !== exp) begin n_errors++; $display("FAIL silent_model got=%b exp=%b", got, exp); end
    endtask

    task automatic test_random();
        logic [4*NCH-1:0] got, exp;
        for (int t = 0; t < 2000; t++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(0, 15) == 0) enable[ch] = ~enable[ch];
                if ($urandom_range(0, 31) == 0) set_sp(ch, int'($urandom_range(0, 6)));
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
            got = {step, dir, homed, sel_n}; exp = exp_all();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL random_model t=%0d got=%b exp=%b", t, got, exp); end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_play();
        bit done = 0;
        logic [4*NCH-1:0] got, exp;
        enable = 2'b11; set_sp(0, 1); set_sp(1, 3);
        for (int t = 0; t < 700 && !done; t++) begin
            tick();
            if (homed === 2'b11) done = 1;
        end
        n_checks++; if (!done) begin n_errors++; $display("FAIL midrst_prehome homed=%b", homed); end
        for (int t = 0; t < 20; t++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if ({step, dir, homed, sel_n} !== 8'b11_11_00_00) begin
            n_errors++; $display("FAIL midrst_state got=%b exp=11110000", {step, dir, homed, sel_n});
        end
        for (int t = 1; t <= 640; t++) begin
            tick();
            got = {step, dir, homed, sel_n}; exp = exp_all();
            n_checks++; if (got !== exp) begin n_errors++; $display("FAIL midrst_model t=%0d got=%b exp=%b", t, got, exp); end
            if (t == 635 || t == 636) begin
                n_checks++;
                if (homed !== ((t == 636) ? 2'b11 : 2'b00)) begin n_errors++; $display("FAIL midrst_homed t=%0d homed=%b", t, homed); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_homing();
        test_bounce();
        test_play_rate();
        test_live_setpoint();
        test_pause_silent();
        test_random();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
